ofs_fim_pcie_ss_sb2ib_gen: RTL and testbench

- Parametrised successor of the side-band-to-in-band (SB2IB) header converter in the PCIe SS shim layer.
- Takes an AXI-S stream whose TLP header travels alongside the data, and emits the header inline at tdata[0] of the SOP beat. The payload is shifted up by HDR_W bits.
- Generalised in data width, header width, and a per-packet bypass for traffic that is already in-band.
- Sits between the one-request-per-cycle, SOP-at-bit-0 mapper and the PCIe SS TX port.

---
 rtl/ofs_fim_pcie_ss_sb2ib_gen.sv | 214 +++++++++++++++++++++
 tb/tb_ofs_fim_pcie_ss_sb2ib_gen.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_fim_pcie_ss_sb2ib_gen.sv
// Side-band to in-band TLP header converter for the PCIe SS TX path.
// Inserts the side-band header at bit 0 of the SOP beat and shifts the
// payload up by HDR_W bits. A packet may instead bypass the conversion
// when its header is already in-band.
// Optional macro OFS_FIM_SB2IB_GEN_ERR_CHK_EN enables a sticky protocol
// checker on err; when it is undefined, err is tied to 0.
module ofs_fim_pcie_ss_sb2ib_gen #(
    parameter int unsigned TDATA_W = 512,
    parameter int unsigned HDR_W   = 256,
    parameter int unsigned USER_W  = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [TDATA_W-1:0]     s_tdata,
    input  logic [TDATA_W/8-1:0]   s_tkeep,
    input  logic                   s_tlast,
    input  logic [USER_W-1:0]      s_tuser,
    input  logic [HDR_W-1:0]       s_hdr,
    input  logic                   s_hdr_nodata,
    input  logic                   s_bypass,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [TDATA_W-1:0]     m_tdata,
    output logic [TDATA_W/8-1:0]   m_tkeep,
    output logic                   m_tlast,
    output logic [USER_W-1:0]      m_tuser,
    output logic                   err
);

    localparam int unsigned KEEP_W  = TDATA_W / 8;
    localparam int unsigned D       = TDATA_W - HDR_W;
    localparam int unsigned K       = D / 8;
    localparam int unsigned HKEEP_W = HDR_W / 8;

    typedef enum logic [1:0] {
        ST_SOP   = 2'd0,
        ST_MID   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_BYP   = 2'd3
    } state_t;

    state_t               state;
    state_t               state_d;
    logic                 load_en;
    logic                 accept;
    logic                 has_carry;
    logic [HDR_W-1:0]     carry_data;
    logic [HDR_W-1:0]     carry_data_d;
    logic [HKEEP_W-1:0]   carry_keep;
    logic [HKEEP_W-1:0]   carry_keep_d;
    logic                 m_tvalid_d;
    logic [TDATA_W-1:0]   m_tdata_d;
    logic [KEEP_W-1:0]    m_tkeep_d;
    logic                 m_tlast_d;
    logic [USER_W-1:0]    m_tuser_d;

    // Output stage accepts a new beat when empty or draining this cycle
    assign load_en   = !m_tvalid || m_tready;
    assign s_tready  = load_en && (state != ST_FLUSH);
    assign accept    = s_tvalid && s_tready;
    assign has_carry = s_tkeep[K];

    // Next-state, next-output and carry computation
    always_comb begin
        state_d      = state;
        m_tvalid_d   = m_tvalid;
        m_tdata_d    = m_tdata;
        m_tkeep_d    = m_tkeep;
        m_tlast_d    = m_tlast;
        m_tuser_d    = m_tuser;
        carry_data_d = carry_data;
        carry_keep_d = carry_keep;
        if (load_en) begin
            m_tvalid_d = 1'b0;
        end
        case (state)
            ST_SOP: begin
                if (accept) begin
                    m_tvalid_d = 1'b1;
                    m_tuser_d  = s_tuser;
                    if (s_bypass) begin
                        m_tdata_d = s_tdata;
                        m_tkeep_d = s_tkeep;
                        m_tlast_d = s_tlast;
                        if (!s_tlast) begin
                            state_d = ST_BYP;
                        end
                    end else if (s_hdr_nodata) begin
                        m_tdata_d = {{D{1'b0}}, s_hdr};
                        m_tkeep_d = {{K{1'b0}}, {HKEEP_W{1'b1}}};
                        m_tlast_d = 1'b1;
                    end else begin
                        m_tdata_d    = {s_tdata[D-1:0], s_hdr};
                        m_tkeep_d    = {s_tkeep[K-1:0], {HKEEP_W{1'b1}}};
                        carry_data_d = s_tdata[TDATA_W-1:D];
                        carry_keep_d = s_tkeep[KEEP_W-1:K];
                        if (!s_tlast) begin
                            m_tlast_d = 1'b0;
                            state_d   = ST_MID;
                        end else if (has_carry) begin
                            m_tlast_d = 1'b0;
                            state_d   = ST_FLUSH;
                        end else begin
                            m_tlast_d = 1'b1;
                        end
                    end
                end
            end
            ST_MID: begin
                if (accept) begin
                    m_tvalid_d   = 1'b1;
                    m_tdata_d    = {s_tdata[D-1:0], carry_data};
                    m_tkeep_d    = {s_tkeep[K-1:0], carry_keep};
                    m_tuser_d    = '0;
                    carry_data_d = s_tdata[TDATA_W-1:D];
                    carry_keep_d = s_tkeep[KEEP_W-1:K];
                    if (s_tlast && has_carry) begin
                        m_tlast_d = 1'b0;
                        state_d   = ST_FLUSH;
                    end else if (s_tlast) begin
                        m_tlast_d = 1'b1;
                        state_d   = ST_SOP;
                    end else begin
                        m_tlast_d = 1'b0;
                    end
                end
            end
            ST_FLUSH: begin
                if (load_en) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = {{D{1'b0}}, carry_data};
                    m_tkeep_d  = {{K{1'b0}}, carry_keep};
                    m_tlast_d  = 1'b1;
                    m_tuser_d  = '0;
                    state_d    = ST_SOP;
                end
            end
            ST_BYP: begin
                if (accept) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = s_tdata;
                    m_tkeep_d  = s_tkeep;
                    m_tlast_d  = s_tlast;
                    m_tuser_d  = s_tuser;
                    if (s_tlast) begin
                        state_d = ST_SOP;
                    end
                end
            end
            default: begin
                state_d = ST_SOP;
            end
        endcase
    end

    // State, carry and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_SOP;
            carry_data <= '0;
            carry_keep <= '0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            m_tkeep    <= '0;
            m_tlast    <= 1'b0;
            m_tuser    <= '0;
        end else begin
            state      <= state_d;
            carry_data <= carry_data_d;
            carry_keep <= carry_keep_d;
            m_tvalid   <= m_tvalid_d;
            m_tdata    <= m_tdata_d;
            m_tkeep    <= m_tkeep_d;
            m_tlast    <= m_tlast_d;
            m_tuser    <= m_tuser_d;
        end
    end

`ifdef OFS_FIM_SB2IB_GEN_ERR_CHK_EN
    logic              err_set;
    logic [KEEP_W-1:0] keep_inc;

    // Flag non-contiguous keep, multi-beat header-only SOP, empty non-SOP beat
    always_comb begin
        keep_inc = s_tkeep + KEEP_W'(1);
        err_set  = 1'b0;
        if (accept) begin
            if ((s_tkeep & keep_inc) != '0) begin
                err_set = 1'b1;
            end
            if ((state == ST_SOP) && s_hdr_nodata && !s_tlast) begin
                err_set = 1'b1;
            end
            if (((state == ST_MID) || (state == ST_BYP)) && (s_tkeep == '0)) begin
                err_set = 1'b1;
            end
        end
    end

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_sb2ib_gen.sv
// Scoreboard bench for ofs_fim_pcie_ss_sb2ib_gen: a byte-stream model
// (header bytes followed by payload bytes, chopped into bus-width beats)
// produces expected output beats; a monitor pops and compares them.
module tb_ofs_fim_pcie_ss_sb2ib_gen;

    localparam int unsigned TDATA_W = 512;
    localparam int unsigned HDR_W   = 256;
    localparam int unsigned USER_W  = 10;
    localparam int unsigned KEEP_W  = TDATA_W / 8;
    localparam int unsigned HB      = HDR_W / 8;

    typedef struct packed {
        logic [TDATA_W-1:0] data;
        logic [KEEP_W-1:0]  keep;
        logic               last;
        logic [USER_W-1:0]  user;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               s_tvalid;
    logic               s_tready;
    logic [TDATA_W-1:0] s_tdata;
    logic [KEEP_W-1:0]  s_tkeep;
    logic               s_tlast;
    logic [USER_W-1:0]  s_tuser;
    logic [HDR_W-1:0]   s_hdr;
    logic               s_hdr_nodata;
    logic               s_bypass;
    logic               m_tvalid;
    logic               m_tready;
    logic [TDATA_W-1:0] m_tdata;
    logic [KEEP_W-1:0]  m_tkeep;
    logic               m_tlast;
    logic [USER_W-1:0]  m_tuser;
    logic               err;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    bit    rdy_mode = 1'b0;

    ofs_fim_pcie_ss_sb2ib_gen #(
        .TDATA_W(TDATA_W),
        .HDR_W  (HDR_W),
        .USER_W (USER_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tlast     (s_tlast),
        .s_tuser     (s_tuser),
        .s_hdr       (s_hdr),
        .s_hdr_nodata(s_hdr_nodata),
        .s_bypass    (s_bypass),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tlast     (m_tlast),
        .m_tuser     (m_tuser),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [TDATA_W-1:0] rand_data();
        logic [TDATA_W-1:0] r;
        for (int i = 0; i < TDATA_W / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [KEEP_W-1:0] rand_keep(input int nb);
        logic [KEEP_W-1:0] k;
        k = '0;
        for (int j = 0; j < nb; j++) k[j] = 1'b1;
        return k;
    endfunction

    // Drive one beat and hold it until accepted (bounded)
    task automatic drive_beat(input logic [TDATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                              input logic l, input logic [USER_W-1:0] u,
                              input logic [HDR_W-1:0] h, input logic nd, input logic byp);
        int n;
        s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u;
        s_hdr = h; s_hdr_nodata = nd; s_bypass = byp; s_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_tready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!s_tready) begin
            total++; bad++;
            $display("FAIL accept_timeout got s_tready=0 want 1");
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    // Converted packet: expected = header bytes then payload bytes, in beats
    task automatic send_conv(input int nbytes, input bit nodata, input int max_beats);
        byte unsigned       pl[$];
        byte unsigned       stream[$];
        logic [TDATA_W-1:0] tmp;
        logic [TDATA_W-1:0] d;
        logic [KEEP_W-1:0]  k;
        logic [HDR_W-1:0]   hdr;
        logic [USER_W-1:0]  user;
        beat_t              e;
        int                 nout;
        int                 nin;
        int                 idx;
        tmp  = rand_data();
        hdr  = tmp[HDR_W-1:0];
        user = USER_W'($urandom);
        for (int i = 0; i < nbytes; i++) pl.push_back(8'($urandom));
        for (int i = 0; i < int'(HB); i++) stream.push_back(hdr[8*i +: 8]);
        if (!nodata) foreach (pl[i]) stream.push_back(pl[i]);
        nout = (stream.size() + int'(KEEP_W) - 1) / int'(KEEP_W);
        for (int b = 0; b < nout; b++) begin
            e = '0;
            for (int j = 0; j < int'(KEEP_W); j++) begin
                idx = b * int'(KEEP_W) + j;
                if (idx < stream.size()) begin
                    e.data[8*j +: 8] = stream[idx];
                    e.keep[j] = 1'b1;
                end
            end
            e.last = (b == nout - 1);
            e.user = (b == 0) ? user : '0;
            exp_q.push_back(e);
        end
        if (nodata) begin
            drive_beat(rand_data(), rand_keep($urandom_range(64, 0)), 1'b1, user, hdr, 1'b1, 1'b0);
        end else begin
            nin = (nbytes + int'(KEEP_W) - 1) / int'(KEEP_W);
            for (int b = 0; b < nin && b < max_beats; b++) begin
                d = '0; k = '0;
                for (int j = 0; j < int'(KEEP_W); j++) begin
                    idx = b * int'(KEEP_W) + j;
                    if (idx < nbytes) begin
                        d[8*j +: 8] = pl[idx];
                        k[j] = 1'b1;
                    end
                end
                tmp = rand_data();
                drive_beat(d, k, b == nin - 1, (b == 0) ? user : USER_W'($urandom),
                           (b == 0) ? hdr : tmp[HDR_W-1:0], 1'b0, 1'b0);
            end
        end
    endtask

    // Bypass packet: every beat expected back unchanged
    task automatic send_byp(input int nbeats, input logic [KEEP_W-1:0] last_keep);
        beat_t              e;
        logic [TDATA_W-1:0] tmp;
        for (int b = 0; b < nbeats; b++) begin
            e.data = rand_data();
            e.keep = (b == nbeats - 1) ? last_keep : {KEEP_W{1'b1}};
            e.last = (b == nbeats - 1);
            e.user = USER_W'($urandom);
            exp_q.push_back(e);
            tmp = rand_data();
            drive_beat(e.data, e.keep, e.last, e.user, tmp[HDR_W-1:0], 1'b0,
                       (b == 0) ? 1'b1 : 1'($urandom));
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d beats outstanding want 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output-side backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = rdy_mode ? ($urandom_range(2, 0) != 0) : 1'b1;
        end
    end

    // Monitor: compare transferred beats and check hold stability
    initial begin
        beat_t got;
        beat_t e;
        beat_t prev;
        bit    hold;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            got = {m_tdata, m_tkeep, m_tlast, m_tuser};
            if (hold && !rst) begin
                total++;
                if (got !== prev || m_tvalid !== 1'b1) begin
                    bad++;
                    $display("FAIL hold_stable got valid=%b last=%b keep=%h want valid=1 last=%b keep=%h",
                             m_tvalid, got.last, got.keep, prev.last, prev.keep);
                end
            end
            hold = m_tvalid && !m_tready && !rst;
            prev = got;
            if (m_tvalid && m_tready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat got keep=%h last=%b want no beat", got.keep, got.last);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        bad++;
                        $display("FAIL beat got d=%h k=%h l=%b u=%h want d=%h k=%h l=%b u=%h",
                                 got.data, got.keep, got.last, got.user,
                                 e.data, e.keep, e.last, e.user);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0;
        s_hdr = '0; s_hdr_nodata = 1'b0; s_bypass = 1'b0; m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got valid=%b keep=%h err=%b want all zero", m_tvalid, m_tkeep, err);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Header-only, short, and single-beat carry packets
        send_conv(0, 1'b1, 99);
        wait_drain();
        send_conv(16, 1'b0, 99);
        wait_drain();
        send_conv(64, 1'b0, 99);
        @(negedge clk);
        total++;
        if (s_tready !== 1'b0) begin
            bad++;
            $display("FAIL flush_tready got %b want 0", s_tready);
        end
        wait_drain();

        // Three full beats then back-to-back packets
        send_conv(192, 1'b0, 99);
        send_conv(40, 1'b0, 99);
        send_conv(100, 1'b0, 99);
        wait_drain();

        // Bypass then converted packet
        send_byp(2, rand_keep(20));
        send_conv(70, 1'b0, 99);
        wait_drain();

        // Randomised traffic with random backpressure
        rdy_mode = 1'b1;
        for (int p = 0; p < 150; p++) begin
            case ($urandom_range(3, 0))
                0:       send_conv(0, 1'b1, 99);
                1:       send_byp($urandom_range(3, 1), rand_keep($urandom_range(64, 1)));
                default: send_conv($urandom_range(250, 1), 1'b0, 99);
            endcase
        end
        wait_drain();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_legal got %b want 0", err);
        end

        // Reset in the middle of a packet
        send_conv(256, 1'b0, 2);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        total++;
        if (m_tvalid !== 1'b0 || err !== 1'b0 || m_tkeep !== '0) begin
            bad++;
            $display("FAIL mid_reset got valid=%b err=%b keep=%h want 0 0 0", m_tvalid, err, m_tkeep);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_conv(50, 1'b0, 99);
        send_conv(130, 1'b0, 99);
        wait_drain();

        // Non-contiguous keep
        send_byp(1, 64'h0000_0000_0000_00F0);
        wait_drain();
        total++;
`ifdef OFS_FIM_SB2IB_GEN_ERR_CHK_EN
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_noncontig got %b want 1", err);
        end
`else
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_tied got %b want 0", err);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
